// File: rtl/controle_saida.sv
// Output controller: waits for the multiplier result, shows it on the LEDs in
// three selectable views, and blinks the LEDs when the result never arrives.
module controle_saida #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int BLINK_DIV      = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       done_i,
  input  logic [7:0] result_i,
  input  logic       step_i,
  output logic [7:0] led_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic [1:0] fsm_state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_SHOW  = 2'b10,
    ST_ERROR = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    M_FULL = 2'b00,
    M_HIGH = 2'b01,
    M_LOW  = 2'b10
  } mode_t;

  state_t        state;
  mode_t         mode;
  logic [7:0]    result_r;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] blink_cnt;
  logic          step_r;
  logic          step_prev;
  logic          press;

  // step_i is active-low, so a press is the registered 1 -> 0 transition
  assign press       = step_prev & ~step_r;
  assign fsm_state_o = state;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      M_FULL:  next_mode = M_HIGH;
      M_HIGH:  next_mode = M_LOW;
      default: next_mode = M_FULL;
    endcase
  endfunction

  function automatic logic [7:0] show_led(input mode_t m, input logic [7:0] r);
    case (m)
      M_HIGH:  show_led = {4'h0, r[7:4]};
      M_LOW:   show_led = {4'h0, r[3:0]};
      default: show_led = r;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      mode      <= M_FULL;
      result_r  <= 8'h00;
      to_cnt    <= '0;
      blink_cnt <= '0;
      step_r    <= 1'b1;
      step_prev <= 1'b1;
      led_o     <= 8'h00;
      ready_o   <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      step_r    <= step_i;
      step_prev <= step_r;
      case (state)
        ST_IDLE: begin
          led_o <= 8'h00;
          if (start_i) begin
            state   <= ST_WAIT;
            to_cnt  <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        ST_WAIT: begin
          // a result arriving in the timeout cycle still counts
          if (done_i) begin
            result_r <= result_i;
            mode     <= M_FULL;
            led_o    <= result_i;
            to_cnt   <= '0;
            state    <= ST_SHOW;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            to_cnt    <= '0;
            blink_cnt <= '0;
            led_o     <= 8'hFF;
            state     <= ST_ERROR;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        ST_SHOW: begin
          if (start_i) begin
            state   <= ST_WAIT;
            to_cnt  <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end else if (press) begin
            mode  <= next_mode(mode);
            led_o <= show_led(next_mode(mode), result_r);
          end
        end
        default: begin
          if (press) begin
            state     <= ST_IDLE;
            blink_cnt <= '0;
            led_o     <= 8'h00;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
          end else if (blink_cnt == BL_LAST) begin
            blink_cnt <= '0;
            led_o     <= ~led_o;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_saida.sv
// Directed bench for controle_saida with TIMEOUT_CYCLES=8, BLINK_DIV=4.
module tb_controle_saida;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, done_i, step_i;
  logic [7:0] result_i;
  logic [7:0] led_o;
  logic       ready_o, busy_o;
  logic [1:0] fsm_state_o;

  controle_saida #(.TIMEOUT_CYCLES(8), .BLINK_DIV(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .done_i(done_i),
    .result_i(result_i), .step_i(step_i), .led_o(led_o), .ready_o(ready_o),
    .busy_o(busy_o), .fsm_state_o(fsm_state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst, start, done;
    logic [7:0] res;
    logic       step;
    logic [1:0] st;
    logic [7:0] led;
    logic       rdy, bsy;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic st_, input logic dn, input logic [7:0] res,
                     input logic stp, input logic [1:0] es, input logic [7:0] el,
                     input logic er, input logic eb);
    vec_t v;
    v.rst = rst; v.start = st_; v.done = dn; v.res = res; v.step = stp;
    v.st = es; v.led = el; v.rdy = er; v.bsy = eb;
    vq.push_back(v);
  endtask

  // one press held low 5 cycles, then released 2 cycles
  task automatic add_press(input logic [7:0] prev, input logic [7:0] nxt);
    add(0, 0, 0, 8'h00, 0, 2'b10, prev, 1, 0);
    repeat (4) add(0, 0, 0, 8'h00, 0, 2'b10, nxt, 1, 0);
    repeat (2) add(0, 0, 0, 8'h00, 1, 2'b10, nxt, 1, 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, fsm_state_o, led_o, ready_o, busy_o};
  endfunction

  function automatic logic [31:0] pk(input logic [1:0] s, input logic [7:0] l,
                                     input logic r, input logic b);
    return {20'd0, s, l, r, b};
  endfunction

  task automatic wait_error(output int n);
    n = 0;
    while (fsm_state_o != 2'b11 && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] el;
    // reset, inputs ignored during reset
    add(1, 0, 0, 8'h00, 1, 2'b00, 8'h00, 1, 0);
    add(1, 1, 1, 8'hAA, 0, 2'b00, 8'h00, 1, 0);
    // normal flow
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'h00, 0, 1);
    add(0, 0, 0, 8'h00, 1, 2'b01, 8'h00, 0, 1);
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'h00, 0, 1);
    add(0, 0, 1, 8'hA7, 1, 2'b10, 8'hA7, 1, 0);
    add(0, 0, 0, 8'h00, 1, 2'b10, 8'hA7, 1, 0);
    // mode cycling
    add_press(8'hA7, 8'h0A);
    add_press(8'h0A, 8'h07);
    add_press(8'h07, 8'hA7);
    add_press(8'hA7, 8'h0A);
    // done in SHOW ignored; retained result seen through LOW view
    add(0, 0, 1, 8'h55, 1, 2'b10, 8'h0A, 1, 0);
    add_press(8'h0A, 8'h07);
    // start and press together: start wins, LEDs hold
    add(0, 0, 0, 8'h00, 0, 2'b10, 8'h07, 1, 0);
    add(0, 1, 0, 8'h00, 0, 2'b01, 8'h07, 0, 1);
    repeat (7) add(0, 0, 0, 8'h00, 1, 2'b01, 8'h07, 0, 1);
    // done in the timeout cycle wins
    add(0, 0, 1, 8'h31, 1, 2'b10, 8'h31, 1, 0);
    // capture reset mode to FULL, so next press gives HIGH
    add_press(8'h31, 8'h03);
    // re-run with zero result
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'h03, 0, 1);
    add(0, 0, 0, 8'h00, 1, 2'b01, 8'h03, 0, 1);
    add(0, 0, 1, 8'h00, 1, 2'b10, 8'h00, 1, 0);
    add(0, 0, 0, 8'h00, 1, 2'b10, 8'h00, 1, 0);
    // reset mid-WAIT, late done ignored
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'h00, 0, 1);
    add(0, 0, 0, 8'h00, 1, 2'b01, 8'h00, 0, 1);
    add(0, 0, 0, 8'h00, 1, 2'b01, 8'h00, 0, 1);
    add(1, 0, 0, 8'h00, 1, 2'b00, 8'h00, 1, 0);
    add(0, 0, 1, 8'h99, 1, 2'b00, 8'h00, 1, 0);
    add(0, 1, 0, 8'h00, 1, 2'b01, 8'h00, 0, 1);
    add(0, 0, 1, 8'h5C, 1, 2'b10, 8'h5C, 1, 0);
    add_press(8'h5C, 8'h05);

    rst_i = 1'b1; start_i = 1'b0; done_i = 1'b0; result_i = 8'h00; step_i = 1'b1;
    foreach (vq[i]) begin
      rst_i = vq[i].rst; start_i = vq[i].start; done_i = vq[i].done;
      result_i = vq[i].res; step_i = vq[i].step;
      tick();
      chk($sformatf("vec%0d", i), outs(), pk(vq[i].st, vq[i].led, vq[i].rdy, vq[i].bsy));
    end

    // timeout, blinking with start/done ignored, press back to IDLE
    rst_i = 1'b0; done_i = 1'b0; step_i = 1'b1;
    start_i = 1'b1; tick(); start_i = 1'b0;
    wait_error(n);
    chk("timeout_cycles", n, 8);
    chk("error_entry", outs(), pk(2'b11, 8'hFF, 0, 0));
    for (int k = 1; k <= 9; k++) begin
      start_i = k[0]; done_i = ~k[0]; result_i = 8'h11;
      tick();
      el = (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
      chk($sformatf("blink%0d", k), outs(), pk(2'b11, el, 0, 0));
    end
    start_i = 1'b0; done_i = 1'b0; step_i = 1'b0;
    tick();
    chk("error_press_pending", outs(), pk(2'b11, 8'hFF, 0, 0));
    tick();
    chk("error_press_idle", outs(), pk(2'b00, 8'h00, 1, 0));
    step_i = 1'b1;
    tick();
    chk("idle_after_error", outs(), pk(2'b00, 8'h00, 1, 0));

    // reset mid-blink
    start_i = 1'b1; tick(); start_i = 1'b0;
    wait_error(n);
    chk("timeout_cycles_2", n, 8);
    repeat (5) tick();
    chk("blink_dark", outs(), pk(2'b11, 8'h00, 0, 0));
    rst_i = 1'b1; tick();
    chk("reset_mid_blink", outs(), pk(2'b00, 8'h00, 1, 0));
    rst_i = 1'b0; tick();
    chk("idle_hold", outs(), pk(2'b00, 8'h00, 1, 0));
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("restart_after_reset", outs(), pk(2'b01, 8'h00, 0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_saida.md
CONTROLE_SAIDA -- requirements
Module: controle_saida

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles WAIT holds for done_i before ERROR (legal range >= 2).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000: cycles per LED half-period in ERROR (legal range >= 1).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: operand-load pulse (compute) from the input controller.
REQ-006 The block SHALL have port done_i, input, 1 bit: result-valid pulse from the multiplier.
REQ-007 The block SHALL have port result_i, input, 8 bits: multiplier product, valid only while done_i=1.
REQ-008 The block SHALL have port step_i, input, 1 bit: debounced key, active-low (0 = pressed).
REQ-009 The block SHALL have port led_o, output, 8 bits: registered LED drive.
REQ-010 The block SHALL have port ready_o, output, 1 bit: 1 = the block accepts a new start_i.
REQ-011 The block SHALL have port busy_o, output, 1 bit: 1 = waiting for a result.
REQ-012 The block SHALL have port fsm_state_o, output, 2 bits: current state encoding, for debug.

Function
REQ-013 The FSM SHALL have four states with these encodings: IDLE=2'b00, WAIT=2'b01, SHOW=2'b10, ERROR=2'b11; fsm_state_o SHALL equal the current state.
REQ-014 Press detection SHALL be as follows: step_i is registered each cycle; a press is detected when prev=1 and cur=0, giving exactly one press per falling edge.
REQ-015 IDLE: led_o=8'h00, ready_o=1, busy_o=0; start_i=1 -> WAIT with the timeout counter cleared to 0.
REQ-016 WAIT: ready_o=0, busy_o=1, led_o holds its previous value; start_i is ignored; the counter increments by 1 per cycle.
REQ-017 WAIT, done_i=1: result_i SHALL be captured into an 8-bit result register, display mode set to FULL, next state SHOW; led_o SHALL show the new result on the cycle after the capture edge.
REQ-018 WAIT, no done_i while the counter = TIMEOUT_CYCLES-1: next state SHALL be ERROR.
REQ-019 done_i and the timeout condition in the same cycle: done_i SHALL win (-> SHOW).
REQ-020 SHOW: ready_o=1, busy_o=0; led_o by mode: FULL = result, HIGH = {4'h0, result[7:4]}, LOW = {4'h0, result[3:0]}.
REQ-021 SHOW, press: mode SHALL advance FULL -> HIGH -> LOW -> FULL (wrap-around); a held key SHALL advance only once.
REQ-022 SHOW, done_i: done_i SHALL be ignored and the result register unchanged.
REQ-023 SHOW, start_i=1: next state SHALL be WAIT with the counter cleared; the result register is retained until the next capture.
REQ-024 SHOW, start_i and a press in the same cycle: start_i SHALL win and the mode SHALL be unchanged.
REQ-025 ERROR: ready_o=0, busy_o=0; led_o SHALL be 8'hFF on entry and invert between 8'hFF and 8'h00 every BLINK_DIV cycles via a blink counter cleared on entry.
REQ-026 ERROR, press: next state SHALL be IDLE; start_i and done_i SHALL be ignored in ERROR.
REQ-027 The timeout counter width SHALL be ceil(log2(TIMEOUT_CYCLES)) bits; the blink counter width SHALL be ceil(log2(BLINK_DIV)) bits, minimum 1; neither counter overflows, since both are cleared on reaching their terminal count or on state exit.

Reset
REQ-028 When rst_i=1 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-WAIT and mid-blink.
REQ-029 Reset SHALL set: led_o=8'h00, ready_o=1, busy_o=0, fsm_state_o=2'b00, result register=8'h00, mode=FULL, both counters=0, step register and prev=1.
REQ-030 While rst_i=1, all inputs SHALL be ignored; the first start_i is accepted on the first edge with rst_i=0.

Verification (TIMEOUT_CYCLES=8, BLINK_DIV=4)
REQ-031 Normal flow: reset, start_i pulse, done_i pulse with result_i=8'hA7 three cycles later -> fsm_state_o 00 -> 01 -> 10; busy_o=1 only in WAIT; led_o=8'hA7 one cycle after capture.
REQ-032 Mode cycling: in SHOW with result 8'hA7, four presses (each step_i held low 5 cycles) -> led_o 8'h0A, 8'h07, 8'hA7, 8'h0A, one change per press.
REQ-033 Timeout: start_i, no done_i -> ERROR exactly 8 cycles after WAIT entry; led_o FF for 4 cycles, 00 for 4 cycles, FF...; a press -> IDLE with led_o=8'h00.
REQ-034 Simultaneous events: done_i=1 with result_i=8'h31 in the timeout cycle -> SHOW with led_o=8'h31; in SHOW, start_i plus press in the same cycle -> WAIT with mode unchanged.
REQ-035 Reset mid-operation: rst_i=1 during WAIT (cycle 3), then done_i -> state IDLE, result register 8'h00; the late done_i is ignored.
REQ-036 Re-run from SHOW: start_i then done_i with result_i=8'h00 -> result register updated, led_o=8'h00, mode reset to FULL.
